// File: rtl/grid_block_painter.sv
// ============================================================================
//  Module   : grid_block_painter
//  Purpose  : Paints BLOCKxBLOCK pixel blocks and full-screen black sweeps
//             through the VGA adapter write port. Optional macro: OUTLINE_EN
//             (block perimeter drawn black for a grid look).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module grid_block_painter #(
  parameter int BLOCK    = 3,
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int X_W      = 8,
  parameter int Y_W      = 7
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           req_valid,
  output logic           req_ready,
  input  logic [X_W-1:0] req_x,
  input  logic [Y_W-1:0] req_y,
  input  logic [2:0]     req_colour,
  input  logic           clear_start,
  output logic           clear_done,
  output logic           busy,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [2:0]     vga_colour,
  output logic           vga_plot
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_BLOCK    = 2'd1,
    S_CLEAR    = 2'd2,
    S_CLR_DONE = 2'd3
  } state_t;

  localparam logic [3:0]     O_LAST = 4'(BLOCK - 1);
  localparam logic [X_W-1:0] X_LAST = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(SCREEN_H - 1);
  localparam logic [X_W:0]   X_LIM  = (X_W+1)'(SCREEN_W);
  localparam logic [Y_W:0]   Y_LIM  = (Y_W+1)'(SCREEN_H);
`ifdef OUTLINE_EN
  localparam bit OUTLINE_OK = (BLOCK >= 3);
`endif

  state_t         state, state_n;
  logic [X_W-1:0] bx, bx_n;
  logic [Y_W-1:0] by, by_n;
  logic [2:0]     col, col_n;
  logic [3:0]     ox, ox_n, oy, oy_n;
  logic [X_W-1:0] cx, cx_n;
  logic [Y_W-1:0] cy, cy_n;
  logic [X_W-1:0] x_n;
  logic [Y_W-1:0] y_n;
  logic [2:0]     colour_n;
  logic           plot_n, done_n, blk_pix;
  logic [X_W:0]   sum_x;
  logic [Y_W:0]   sum_y;

  assign req_ready = (state == S_IDLE) && !clear_start;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // Counters always describe the pixel currently presented on the vga_* registers.
  always_comb begin
    state_n  = state;
    bx_n     = bx;
    by_n     = by;
    col_n    = col;
    ox_n     = ox;
    oy_n     = oy;
    cx_n     = cx;
    cy_n     = cy;
    x_n      = vga_x;
    y_n      = vga_y;
    colour_n = vga_colour;
    plot_n   = 1'b0;
    done_n   = 1'b0;
    blk_pix  = 1'b0;
    sum_x    = '0;
    sum_y    = '0;
    case (state)
      S_IDLE: begin
        if (clear_start) begin
          state_n  = S_CLEAR;
          cx_n     = '0;
          cy_n     = '0;
          x_n      = '0;
          y_n      = '0;
          colour_n = 3'b000;
          plot_n   = 1'b1;
        end else if (req_valid) begin
          state_n = S_BLOCK;
          bx_n    = req_x;
          by_n    = req_y;
          col_n   = req_colour;
          ox_n    = 4'd0;
          oy_n    = 4'd0;
          blk_pix = 1'b1;
        end
      end
      S_BLOCK: begin
        if (ox == O_LAST && oy == O_LAST) begin
          state_n = S_IDLE;
        end else begin
          blk_pix = 1'b1;
          if (ox == O_LAST) begin
            ox_n = 4'd0;
            oy_n = oy + 4'd1;
          end else begin
            ox_n = ox + 4'd1;
          end
        end
      end
      S_CLEAR: begin
        if (cx == X_LAST && cy == Y_LAST) begin
          state_n = S_CLR_DONE;
          done_n  = 1'b1;
        end else begin
          if (cx == X_LAST) begin
            cx_n = '0;
            cy_n = cy + Y_W'(1);
          end else begin
            cx_n = cx + X_W'(1);
          end
          x_n      = cx_n;
          y_n      = cy_n;
          colour_n = 3'b000;
          plot_n   = 1'b1;
        end
      end
      S_CLR_DONE: begin
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase

    // Extra top bit keeps off-screen pixels from wrapping back onto the screen.
    if (blk_pix) begin
      sum_x  = {1'b0, bx_n} + (X_W+1)'(ox_n);
      sum_y  = {1'b0, by_n} + (Y_W+1)'(oy_n);
      x_n    = sum_x[X_W-1:0];
      y_n    = sum_y[Y_W-1:0];
      plot_n = (sum_x < X_LIM) && (sum_y < Y_LIM);
`ifdef OUTLINE_EN
      if (OUTLINE_OK && (ox_n == 4'd0 || ox_n == O_LAST || oy_n == 4'd0 || oy_n == O_LAST))
        colour_n = 3'b000;
      else
        colour_n = col_n;
`else
      colour_n = col_n;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bx         <= '0;
      by         <= '0;
      col        <= 3'b000;
      ox         <= 4'd0;
      oy         <= 4'd0;
      cx         <= '0;
      cy         <= '0;
      vga_x      <= '0;
      vga_y      <= '0;
      vga_colour <= 3'b000;
      vga_plot   <= 1'b0;
      clear_done <= 1'b0;
    end else begin
      bx         <= bx_n;
      by         <= by_n;
      col        <= col_n;
      ox         <= ox_n;
      oy         <= oy_n;
      cx         <= cx_n;
      cy         <= cy_n;
      vga_x      <= x_n;
      vga_y      <= y_n;
      vga_colour <= colour_n;
      vga_plot   <= plot_n;
      clear_done <= done_n;
    end
  end

endmodule

`default_nettype wire
